// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart block.
//   rx_state_e    : receive FSM states (IDLE/START/DATA/STOP)
//   DIV_WIDTH_DEF : default width of the bit-period divider input
package uart_pkg;

  localparam int unsigned DIV_WIDTH_DEF  = 16;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for an asynchronous single-bit input.
//   clk_i  : destination clock
//   rst_ni : async reset, low-active; both flops load RESET_VAL
//   d_i    : asynchronous input
//   q_o    : synchronised output (two clock latency)
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready output and error pulses.
//   main_clk_i    : clock
//   main_rst_an_i : async reset, low-active
//   en_i          : receiver enable; low aborts any frame in progress
//   clkdiv_i      : clocks per bit minus 1 (>= 3); change only while idle
//   rx_i          : asynchronous serial line, idle high
//   rx_data_o     : received byte, held while rx_valid_o is high
//   rx_valid_o    : byte available; cleared on rx_valid_o & rx_ready_i
//   rx_ready_i    : consumer ready
//   frame_err_o   : 1-cycle pulse, stop bit sampled low (byte dropped)
//   overrun_o     : 1-cycle pulse, good byte dropped because output was full
//   busy_o        : receiver FSM not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_an_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  clkdiv_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;

  logic                  rxs;
  logic                  rxs_q;
  rx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  tick;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (main_clk_i),
    .rst_ni (main_rst_an_i),
    .d_i    (rx_i),
    .q_o    (rxs)
  );

  assign tick = (cnt_q == '0);

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      rxs_q   <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rxs_q   <= rxs;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    // Accept clears valid; a byte landing this cycle overrides below.
    valid_d = valid_q & ~rx_ready_i;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (!en_i) begin
      state_d = RX_IDLE;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          // Edge detect only: a line held low (break) never retriggers.
          if (!rxs && rxs_q) begin
            cnt_d   = clkdiv_i >> 1;
            state_d = RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (!rxs) begin
              cnt_d   = clkdiv_i;
              idx_d   = '0;
              state_d = RX_DATA;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            shreg_d = {rxs, shreg_q[DATA_WIDTH-1:1]};
            cnt_d   = clkdiv_i;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
              state_d = RX_STOP;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (tick) begin
            state_d = RX_IDLE;
            if (!rxs) begin
              ferr_d = 1'b1;
            end else if (!valid_q || rx_ready_i) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT = 16;  // clkdiv = 15

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] clkdiv = 16'd15;
  logic        rx = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  uart_rx #(
    .DIV_WIDTH  (16),
    .DATA_WIDTH (8)
  ) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .en_i          (en),
    .clkdiv_i      (clkdiv),
    .rx_i          (rx),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (ready),
    .frame_err_o   (frame_err),
    .overrun_o     (overrun),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int vrise_cyc = -1;
  int ferr_seen = 0, ovr_seen = 0;
  int ferr_exp = 0, ovr_exp = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
               name, act, act, want, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: outcome of a frame is decided by the frame itself and the
  // consumer state when it starts (ready is held steady per scenario).
  task automatic send(input logic [7:0] b, input logic stop);
    if (!stop) ferr_exp++;
    else if (exp_q.size() > 0 && !ready) ovr_exp++;
    else exp_q.push_back(b);
    start_cyc = cyc;
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BIT);
    end
    rx = stop;
    tick(BIT);
  endtask

  // Compare process: data presented must be the oldest expected byte;
  // accepts consume it; error pulses are tallied against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && !valid_prev && vrise_cyc < 0) vrise_cyc = cyc;
      if (rx_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          check("rx_data", rx_data, exp_q[0]);
          if (ready) void'(exp_q.pop_front());
        end
      end
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
    end
    valid_prev = rx_valid;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);

    // 0xA5, latency check, held until accepted
    ready = 1'b0;
    vrise_cyc = -1;
    send(8'hA5, 1'b1);
    rx = 1'b1;
    tick(20);
    check("latency_152pm3", int'((vrise_cyc - start_cyc) >= 149 && (vrise_cyc - start_cyc) <= 155), 1);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    ready = 1'b1;
    tick(3);
    check("a5_drained", exp_q.size(), 0);
    check("a5_valid_clear", rx_valid, 0);

    // back-to-back with ready high
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    rx = 1'b1;
    tick(20);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_no_ovr", ovr_seen, 0);
    check("b2b_last_data", rx_data, 8'hC3);

    // overrun: 0x11 held, 0x22 dropped
    ready = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rx = 1'b1;
    tick(20);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_count", ovr_seen, 1);
    check("ovr_model", ovr_seen, ovr_exp);
    ready = 1'b1;
    tick(3);
    check("ovr_drained", exp_q.size(), 0);

    // framing error then 40-bit break
    send(8'h55, 1'b0);
    tick(40 * BIT);
    check("ferr_count", ferr_seen, 1);
    check("break_idle", busy, 0);
    check("break_no_valid", rx_valid, 0);
    rx = 1'b1;
    tick(40);
    check("break_release_idle", busy, 0);

    // 4-clock glitch
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(6);
    check("glitch_busy", busy, 1);
    tick(30);
    check("glitch_idle", busy, 0);
    check("glitch_no_ferr", ferr_seen, 1);
    check("glitch_no_valid", rx_valid, 0);

    // reset mid-DATA, then clean frame
    rx = 1'b0; tick(BIT);
    rx = 1'b1; tick(BIT);
    rx = 1'b0; tick(BIT);
    check("rst_abort_busy", busy, 1);
    rst_n = 1'b0;
    tick(2);
    check("rst_abort_idle", busy, 0);
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    send(8'h7E, 1'b1);
    rx = 1'b1;
    tick(20);
    check("rst_7e_drained", exp_q.size(), 0);
    check("rst_7e_data", rx_data, 8'h7E);

    // en_i low mid-DATA, then clean frame
    rx = 1'b0; tick(BIT);
    rx = 1'b0; tick(BIT);
    rx = 1'b1; tick(BIT);
    check("en_abort_busy", busy, 1);
    en = 1'b0;
    tick(2);
    check("en_abort_idle", busy, 0);
    rx = 1'b1;
    tick(BIT * 10);
    en = 1'b1;
    tick(10);
    check("en_abort_no_flags", ferr_seen + ovr_seen, 2);
    ready = 1'b0;
    send(8'h7E, 1'b1);
    rx = 1'b1;
    tick(20);
    check("en_7e_valid", rx_valid, 1);
    check("en_7e_data", rx_data, 8'h7E);
    ready = 1'b1;
    tick(3);

    check("final_drained", exp_q.size(), 0);
    check("final_ferr", ferr_seen, ferr_exp);
    check("final_ovr", ovr_seen, ovr_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
